// File: rtl/dds_phase_accum_mc_if.sv
// Control/write bus and phase outputs of the multi-channel DDS phase accumulator.
// The master drives shadow writes, update and clear; the slave returns phase, wrap and valid.
interface dds_phase_accum_mc_if #(
    parameter int NCH   = 2,
    parameter int W_ACC = 32,
    parameter int W_OUT = 16
);
    localparam int W_CH = (NCH > 1) ? $clog2(NCH) : 1;

    logic                   wr_en;
    logic [W_CH-1:0]        wr_ch;
    logic                   wr_sel;
    logic [W_ACC-1:0]       wr_data;
    logic                   update;
    logic [NCH-1:0]         clr;
    logic [NCH*W_OUT-1:0]   phase;
    logic [NCH-1:0]         wrap;
    logic                   valid;

    modport master (
        output wr_en, wr_ch, wr_sel, wr_data, update, clr,
        input  phase, wrap, valid
    );

    modport slave (
        input  wr_en, wr_ch, wr_sel, wr_data, update, clr,
        output phase, wrap, valid
    );
endinterface

// File: rtl/dds_phase_accum_mc.sv
// NCH-channel DDS phase accumulator with double-buffered FTW/POW, per-channel clear,
// carry-out wrap flags and a registered phase output one CE cycle behind the accumulator.
module dds_phase_accum_mc #(
    parameter int NCH   = 2,
    parameter int W_ACC = 32,
    parameter int W_OUT = 16
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   CE,
    dds_phase_accum_mc_if.slave    bus
);
    localparam int W_CH = (NCH > 1) ? $clog2(NCH) : 1;

    logic [W_ACC-1:0] r_acc     [NCH];
    logic [W_ACC-1:0] r_ftw_sh  [NCH];
    logic [W_ACC-1:0] r_pow_sh  [NCH];
    logic [W_ACC-1:0] r_ftw_act [NCH];
    logic [W_ACC-1:0] r_pow_act [NCH];
    logic [W_OUT-1:0] r_phase   [NCH];
    logic [NCH-1:0]   r_wrap;
    logic             r_valid;

    logic [W_ACC:0]   w_sum     [NCH];
    logic [W_ACC-1:0] w_ofs     [NCH];

    // Carry-extended accumulate sum and offset phase, both from pre-edge state
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            w_sum[c] = {1'b0, r_acc[c]} + {1'b0, r_ftw_act[c]};
            w_ofs[c] = r_acc[c] + r_pow_act[c];
        end
    end

    // Shadow registers: written regardless of CE; channel indices beyond NCH match nothing
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int c = 0; c < NCH; c++) begin
                r_ftw_sh[c] <= {W_ACC{1'b0}};
                r_pow_sh[c] <= {W_ACC{1'b0}};
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (bus.wr_en && (bus.wr_ch == W_CH'(c))) begin
                    if (bus.wr_sel) begin
                        r_pow_sh[c] <= bus.wr_data;
                    end else begin
                        r_ftw_sh[c] <= bus.wr_data;
                    end
                end
            end
        end
    end

    // Accumulate/clear, phase output and active-register update, all gated by CE
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int c = 0; c < NCH; c++) begin
                r_acc[c]     <= {W_ACC{1'b0}};
                r_ftw_act[c] <= {W_ACC{1'b0}};
                r_pow_act[c] <= {W_ACC{1'b0}};
                r_phase[c]   <= {W_OUT{1'b0}};
            end
            r_wrap  <= {NCH{1'b0}};
            r_valid <= 1'b0;
        end else if (CE) begin
            for (int c = 0; c < NCH; c++) begin
                if (bus.clr[c]) begin
                    r_acc[c]  <= {W_ACC{1'b0}};
                    r_wrap[c] <= 1'b0;
                end else begin
                    r_acc[c]  <= w_sum[c][W_ACC-1:0];
                    r_wrap[c] <= w_sum[c][W_ACC];
                end
                r_phase[c] <= w_ofs[c][W_ACC-1 -: W_OUT];
                // Non-blocking copy picks up the shadow value from before any same-edge write
                if (bus.update) begin
                    r_ftw_act[c] <= r_ftw_sh[c];
                    r_pow_act[c] <= r_pow_sh[c];
                end
            end
            r_valid <= 1'b1;
        end else begin
            r_valid <= 1'b0;
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_phase
        assign bus.phase[g*W_OUT +: W_OUT] = r_phase[g];
    end

    assign bus.wrap  = r_wrap;
    assign bus.valid = r_valid;
endmodule

// File: doc/dds_phase_accum_mc.md
# dds_phase_accum_mc

Multi-channel phase accumulator for the DDS core. It is the next generation of the single-channel accumulator, adding NCH independent channels, wider accumulators, a per-channel phase offset, double-buffered tuning words with an atomic update strobe, per-channel synchronous phase clear, and wrap (carry-out) flags. It feeds the phase-to-amplitude stage; each channel's phase output is the truncated sum of the accumulator and the offset.

## Interface
- NCH, 2: number of independent channels (≥1)
- W_ACC, 32: accumulator, FTW and POW width in bits
- W_OUT, 16: output phase width; the top W_OUT bits of the W_ACC sum (1 ≤ W_OUT ≤ W_ACC)
- CLK  in  1  clock; all logic on rising edge
- RESET  in  1  reset, synchronous, active-high
- CE  in  1  clock enable for accumulate/update/clear/output
- wr_en  in  1  shadow register write strobe
- wr_ch  in  max(1,clog2(NCH))  target channel
- wr_sel  in  1  0 = FTW shadow, 1 = POW shadow
- wr_data  in  W_ACC  value written
- update  in  1  copy all shadow registers to active registers (all channels)
- clr  in  NCH  per-channel accumulator clear
- phase  out  NCH*W_OUT  channel c occupies bits [c*W_OUT +: W_OUT]
- wrap  out  NCH  per-channel carry-out of the last accumulate
- valid  out  1  phase was refreshed on the previous edge

## Operation
- Per-channel state: acc, ftw_sh, pow_sh, ftw_act, pow_act (all W_ACC bits).
- RESET overrides everything, including CE=0. It zeroes all state, phase, wrap and valid.
- Shadow writes ignore CE. On wr_en, wr_data goes to ftw_sh[wr_ch] or pow_sh[wr_ch]. If wr_ch ≥ NCH, the write is ignored with no side effects.
- When CE=0 (and no RESET): acc, active registers, phase, wrap are held. valid ← 0.
- When CE=1, for each channel c:
  - if clr[c]: acc ← 0, wrap[c] ← 0;
  - else: {wrap[c], acc} ← acc + ftw_act (W_ACC+1-bit sum; acc wraps modulo 2^W_ACC).
  - phase[c] ← (acc + pow_act) mod 2^W_ACC, bits [W_ACC-1 : W_ACC-W_OUT]. This uses the pre-edge acc and pow_act values.
  - if update: ftw_act ← ftw_sh, pow_act ← pow_sh for all channels.
  - valid ← 1.
- Simultaneous events:
  - update and accumulate in the same cycle: the accumulate uses the old ftw_act; the new FTW first affects the next CE cycle.
  - wr_en and update in the same cycle: active registers receive the pre-write shadow value; the new data is applied only by a later update.
  - clr and update together: both happen; clr wins over accumulate.
- update with CE=0 is ignored (not latched).
- No further ordering between channels; each channel is independent.

## Timing
- Shadow write to active: requires one update with CE=1 on an edge after the write edge.
- ftw_act change to acc effect: the next CE edge.
- acc to phase: one CE cycle. phase on edge k reflects acc before edge k, i.e. output latency is 1 CE cycle.
- After RESET release, the first CE edge gives phase = 0, acc = ftw_act = 0.
- wrap is a registered level, valid for one CE cycle, and held while CE=0.
- Fully pipelined: one accumulate per channel per CE cycle, no stalls, no backpressure.

## Test plan
All scenarios use NCH=2, W_ACC=8, W_OUT=4.
- **Reset defaults.** Assert RESET with CE=0 → phase=0, wrap=0, valid=0. With CE=1 and no writes → phase stays 0 indefinitely.
- **Accumulate and wrap.** Write ch0 FTW=0x40, pulse update, then run CE continuously. Successive acc values are 0x40, 0x80, 0xC0, 0x00 (wrap[0]=1 on that edge only). phase[0] follows 0x0, 0x4, 0x8, 0xC, 0x0, lagging by one. ch1 stays 0.
- **Offset.** ch1 FTW=0x10, POW=0xF8, update. phase[1] sequence is 0xF, 0x0, 0x1 (the offset sum wraps). wrap[1]=0 until acc overflows after 16 steps.
- **Double buffering.** While ch0 runs at 0x40, write FTW=0x01 without update → rate unchanged. Pulse update together with a second write of 0x02 → the rate becomes 0x01 on the following CE cycle, not 0x02.
- **Clear and CE gating.**
  - clr[0] with update → acc0=0 next edge; ch1 unaffected.
  - CE=0 for 3 cycles → phase and wrap hold, valid=0.
  - RESET during CE=0 → everything is zero on the next edge.
- **Bad channel.** A write with wr_ch=1 while NCH=1 (separate build) is ignored; active and shadow registers are unchanged.
